door_sprite_engine: RTL and testbench
=====================================

DOOR_SPRITE_ENGINE -- requirements
Module: door_sprite_engine

Interface
REQ-001 Parameter N_DOORS, default 4: number of independently animated doors; range 1..8.
REQ-002 Parameter SPRITE_W / SPRITE_H, default 20 / 20: door sprite size in 320x240 game pixels.
REQ-003 Parameter FRAMES, default 4: animation frames per door; range 2..8; frame 0 = locked, frame FRAMES-1 = open.
REQ-004 Parameter ANIM_DIV, default 6: frame_tick pulses per animation step; range 1..63.
REQ-005 Parameter DOOR_XY, default all zero: packed 18*N_DOORS bits; per door {x[8:0], y[8:0]}, top-left screen position.
REQ-006 Parameter SHEET_X0 / SHEET_Y0, default 120 / 40: top-left of frame 0 in the 320-wide sprite sheet; frame f sits at SHEET_X0 + f*SPRITE_W.
REQ-007 clk  in  1  system clock; one clock domain.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 state  in  4  game state (package encoding).
REQ-010 h_cnt, v_cnt  in  10 each  VGA 640x480 counters.
REQ-011 frame_tick  in  1  one-cycle pulse per video frame.
REQ-012 lock  in  N_DOORS  per-door lock request; 1 = locked, 0 = open.
REQ-013 pixel_addr  out  17  sprite-sheet address; always < 76800.
REQ-014 isObject  out  1  current pixel belongs to a door.
REQ-015 door_open  out  N_DOORS  1 while the door is fully open (frame FRAMES-1, stable).

Function
REQ-016 Screen coordinate: x = h_cnt>>1, y = v_cnt>>1 (9 bits each, 320x240).
REQ-017 Door i hit: DOOR_X(i) <= x < DOOR_X(i)+SPRITE_W and DOOR_Y(i) <= y < DOOR_Y(i)+SPRITE_H.
REQ-018 Overlapping hits: lowest index wins.
REQ-019 Address: (x-DOOR_X + SHEET_X0 + f*SPRITE_W) + (y-DOOR_Y + SHEET_Y0)*320, where f is the winning door's current frame.
REQ-020 pixel_addr and isObject registered; latency exactly 1 clk from h_cnt/v_cnt.
REQ-021 No hit, or state not in {STAGE1, STAGE2, STAGE3}: isObject = 0, pixel_addr = 0.
REQ-022 Per-door FSM states: LOCKED, OPENING, OPEN, CLOSING.
REQ-023 LOCKED with lock=0 -> OPENING; OPEN with lock=1 -> CLOSING.
REQ-024 OPENING: frame +1 every ANIM_DIV frame_ticks; at FRAMES-1 -> OPEN.
REQ-025 CLOSING: frame -1 every ANIM_DIV frame_ticks; at 0 -> LOCKED.
REQ-026 lock=1 in OPENING -> CLOSING from the current frame; lock=0 in CLOSING -> OPENING from the current frame; the step divider restarts at 0 on reversal.
REQ-027 Frame never wraps; it saturates at 0 and FRAMES-1.
REQ-028 Any change of state: all FSMs go to LOCKED, frame 0, divider 0, on the next clk edge; this overrides lock and frame_tick that cycle.
REQ-029 frame_tick and a lock change in the same cycle: the transition applies first; the tick counts toward the new direction.

Reset
REQ-030 rst=1: all FSMs LOCKED, frames 0, dividers 0, pixel_addr = 0, isObject = 0, door_open = 0, immediately and asynchronously.
REQ-031 Release: normal operation from the first clk edge after rst deasserts; a reset mid-animation discards progress.

Configuration
REQ-032 Macro DOOR_ANIM_EN defined: animated behaviour per REQ-022..REQ-027.
REQ-033 Macro DOOR_ANIM_EN undefined: no divider; frame = lock ? 0 : FRAMES-1 on the next clk edge; ANIM_DIV ignored; door_open = ~lock registered.

Structure
REQ-034 Package game_pkg holds the state encoding (TITLE=0, STAFF=1, STAGE1=2, SUCCESS1=3, STAGE2=4, SUCCESS2=5, STAGE3=6, SUCCESS3=7, FAIL=8), SCREEN_W=320, SCREEN_H=240, SHEET_SIZE=76800, and the door FSM state enum.
REQ-035 Sub-module door_anim_fsm, instantiated N_DOORS times: lock, frame_tick and state_change in; frame and door_open out.
REQ-036 The hit test, priority and address calculation are in the top level.

Verification
REQ-037 rst pulse mid-OPENING at frame 2 -> all outputs 0 asynchronously; frame 0 after release.
REQ-038 state=STAGE1, door0 at (260,120), lock=1, h_cnt=520, v_cnt=240 -> next clk: isObject=1, pixel_addr=120+40*320=12920.
REQ-039 lock0 falls, ANIM_DIV=6 -> frame 1 after 6 ticks, 2 after 12 ticks, OPEN and door_open0=1 after 18 ticks.
REQ-040 lock0 rises at frame 2 during OPENING -> CLOSING; frame 1 after 6 more ticks, LOCKED after 12 ticks.
REQ-041 Doors 1 and 2 overlap at pixel (100,100) -> pixel_addr uses door 1's frame.
REQ-042 state STAGE1->SUCCESS1 with door OPEN -> isObject=0 and door_open=0 next cycle; return to STAGE2 -> door shows frame 0.

Source files
------------

// File: rtl/door_sprite_engine_pkg.sv
// Shared game definitions: game-state encoding, screen/sheet geometry and door FSM states.
package game_pkg;

    typedef enum logic [3:0] {
        TITLE    = 4'd0,
        STAFF    = 4'd1,
        STAGE1   = 4'd2,
        SUCCESS1 = 4'd3,
        STAGE2   = 4'd4,
        SUCCESS2 = 4'd5,
        STAGE3   = 4'd6,
        SUCCESS3 = 4'd7,
        FAIL     = 4'd8
    } game_state_e;

    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int SHEET_SIZE = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {
        LOCKED,
        OPENING,
        OPEN,
        CLOSING
    } door_state_e;

    function automatic logic is_stage(input logic [3:0] s);
        return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
    endfunction

endpackage

// File: rtl/door_sprite_engine_if.sv
// Game-side bus of the door sprite engine: raster/game inputs and sprite outputs.
interface door_sprite_engine_if
    import game_pkg::*;
#(
    parameter int N_DOORS = 4
);
    logic [3:0]                    state;
    logic [9:0]                    h_cnt;
    logic [9:0]                    v_cnt;
    logic                          frame_tick;
    logic [N_DOORS-1:0]            lock;
    logic [$clog2(SHEET_SIZE)-1:0] pixel_addr;
    logic                          isObject;
    logic [N_DOORS-1:0]            door_open;

    modport master (
        output state, h_cnt, v_cnt, frame_tick, lock,
        input  pixel_addr, isObject, door_open
    );

    modport slave (
        input  state, h_cnt, v_cnt, frame_tick, lock,
        output pixel_addr, isObject, door_open
    );
endinterface

// File: rtl/door_sprite_engine_anim_fsm.sv
// Per-door animation: moves the frame index between locked (0) and open (FRAMES-1).
// Define DOOR_ANIM_EN for stepped animation; otherwise the frame follows lock directly.
module door_anim_fsm
    import game_pkg::*;
#(
    parameter int FRAMES   = 4,
    parameter int ANIM_DIV = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock,
    input  logic       frame_tick,
    input  logic       state_change,
    output logic [2:0] frame,
    output logic       door_open
);
`ifdef DOOR_ANIM_EN
    door_state_e st_q, st_d;
    logic [2:0]  frame_q, frame_d;
    logic [5:0]  div_q, div_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= LOCKED;
            frame_q <= '0;
            div_q   <= '0;
        end else begin
            st_q    <= st_d;
            frame_q <= frame_d;
            div_q   <= div_d;
        end
    end

    // Direction changes are resolved before the tick so a same-cycle tick counts toward the new direction.
    always_comb begin
        st_d    = st_q;
        frame_d = frame_q;
        div_d   = div_q;
        if (state_change) begin
            st_d    = LOCKED;
            frame_d = '0;
            div_d   = '0;
        end else begin
            case (st_q)
                LOCKED:  if (!lock) begin st_d = OPENING; div_d = '0; end
                OPEN:    if (lock)  begin st_d = CLOSING; div_d = '0; end
                OPENING: if (lock)  begin st_d = CLOSING; div_d = '0; end
                CLOSING: if (!lock) begin st_d = OPENING; div_d = '0; end
                default: st_d = LOCKED;
            endcase
            if (frame_tick && (st_d == OPENING || st_d == CLOSING)) begin
                if (div_d == 6'(ANIM_DIV - 1)) begin
                    div_d = '0;
                    if (st_d == OPENING) begin
                        if (frame_q < 3'(FRAMES - 1)) frame_d = frame_q + 3'd1;
                        if (frame_d == 3'(FRAMES - 1)) st_d = OPEN;
                    end else begin
                        if (frame_q != 3'd0) frame_d = frame_q - 3'd1;
                        if (frame_d == 3'd0) st_d = LOCKED;
                    end
                end else begin
                    div_d = div_d + 6'd1;
                end
            end
        end
    end

    assign frame     = frame_q;
    assign door_open = (st_q == OPEN);
`else
    localparam int unused_div = ANIM_DIV;
    logic       unused_tick;
    logic [2:0] frame_q, frame_d;
    logic       open_q, open_d;

    assign unused_tick = frame_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            open_q  <= 1'b0;
        end else begin
            frame_q <= frame_d;
            open_q  <= open_d;
        end
    end

    always_comb begin
        frame_d = (state_change || lock) ? 3'd0 : 3'(FRAMES - 1);
        open_d  = !state_change && !lock;
    end

    assign frame     = frame_q;
    assign door_open = open_q;
`endif
endmodule

// File: rtl/door_sprite_engine.sv
// Door sprite engine: hit-tests the raster against N_DOORS doors and emits sprite-sheet addresses.
// Animation style is selected by the DOOR_ANIM_EN macro inside door_anim_fsm.
module door_sprite_engine
    import game_pkg::*;
#(
    parameter int                    N_DOORS  = 4,
    parameter int                    SPRITE_W = 20,
    parameter int                    SPRITE_H = 20,
    parameter int                    FRAMES   = 4,
    parameter int                    ANIM_DIV = 6,
    parameter logic [18*N_DOORS-1:0] DOOR_XY  = '0,
    parameter int                    SHEET_X0 = 120,
    parameter int                    SHEET_Y0 = 40
) (
    input logic                 clk,
    input logic                 rst,
    door_sprite_engine_if.slave bus
);
    logic [3:0]         prev_state_q, prev_state_d;
    logic               prev_valid_q, prev_valid_d;
    logic               state_change;
    logic [2:0]         frame [N_DOORS];
    logic [N_DOORS-1:0] door_open;
    logic [16:0]        pixel_addr_q, pixel_addr_d;
    logic               is_object_q, is_object_d;
    logic [8:0]         x, y, dx, dy, off_x, off_y;
    logic [2:0]         sel_frame;
    logic               hit;
    logic [16:0]        raw_addr;

    // The first edge after reset has no previous state to compare against.
    always_comb begin
        prev_state_d = bus.state;
        prev_valid_d = 1'b1;
        state_change = prev_valid_q && (bus.state != prev_state_q);
    end

    for (genvar i = 0; i < N_DOORS; i++) begin : g_door
        door_anim_fsm #(
            .FRAMES   (FRAMES),
            .ANIM_DIV (ANIM_DIV)
        ) u_fsm (
            .clk          (clk),
            .rst          (rst),
            .lock         (bus.lock[i]),
            .frame_tick   (bus.frame_tick),
            .state_change (state_change),
            .frame        (frame[i]),
            .door_open    (door_open[i])
        );
    end

    assign bus.door_open = door_open;

    // Scanning from the highest index down lets the lowest-index hit overwrite the rest.
    always_comb begin
        x         = bus.h_cnt[9:1];
        y         = bus.v_cnt[9:1];
        dx        = '0;
        dy        = '0;
        off_x     = '0;
        off_y     = '0;
        sel_frame = '0;
        hit       = 1'b0;
        for (int i = N_DOORS - 1; i >= 0; i--) begin
            dx = DOOR_XY[18*i+9 +: 9];
            dy = DOOR_XY[18*i +: 9];
            if ({1'b0, x} >= {1'b0, dx} && {1'b0, x} < {1'b0, dx} + 10'(SPRITE_W) &&
                {1'b0, y} >= {1'b0, dy} && {1'b0, y} < {1'b0, dy} + 10'(SPRITE_H)) begin
                hit       = 1'b1;
                off_x     = x - dx;
                off_y     = y - dy;
                sel_frame = frame[i];
            end
        end
        raw_addr = 17'(off_x) + 17'(SHEET_X0) + 17'(sel_frame) * 17'(SPRITE_W)
                 + (17'(off_y) + 17'(SHEET_Y0)) * 17'(SCREEN_W);
        is_object_d  = hit && is_stage(bus.state);
        pixel_addr_d = (is_object_d && raw_addr < 17'(SHEET_SIZE)) ? raw_addr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state_q <= '0;
            prev_valid_q <= 1'b0;
            pixel_addr_q <= '0;
            is_object_q  <= 1'b0;
        end else begin
            prev_state_q <= prev_state_d;
            prev_valid_q <= prev_valid_d;
            pixel_addr_q <= pixel_addr_d;
            is_object_q  <= is_object_d;
        end
    end

    assign bus.pixel_addr = pixel_addr_q;
    assign bus.isObject   = is_object_q;
endmodule

// File: tb/tb_door_sprite_engine.sv
// Randomized bench for door_sprite_engine with a behavioural door/raster model.
// Follows the DOOR_ANIM_EN macro to match whichever animation build is compiled.
module tb_door_sprite_engine;
    import game_pkg::*;

    localparam int N    = 4;
    localparam int SW   = 20;
    localparam int SH   = 20;
    localparam int F    = 4;
    localparam int ADIV = 6;
    localparam logic [18*N-1:0] XY = {9'd10, 9'd200, 9'd95, 9'd95, 9'd90, 9'd90, 9'd260, 9'd120};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    door_sprite_engine_if #(.N_DOORS(N)) bus();

    door_sprite_engine #(
        .N_DOORS  (N),
        .SPRITE_W (SW),
        .SPRITE_H (SH),
        .FRAMES   (F),
        .ANIM_DIV (ADIV),
        .DOOR_XY  (XY),
        .SHEET_X0 (120),
        .SHEET_Y0 (40)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int door_x [N] = '{260, 90, 95, 10};
    int door_y [N] = '{120, 90, 95, 200};

    // Model state: frame per door, motion direction (+1 opening, -1 closing, 0 at rest), ticks so far.
    int          m_frame [N];
    int          m_dir   [N];
    int          m_ticks [N];
    logic [3:0]  m_prev_state;
    bit          m_prev_valid;
    logic [16:0] exp_addr;
    logic        exp_obj;
    logic [N-1:0] exp_open;

    task automatic expectEq(input string name, input int unsigned actual, input int unsigned expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < N; i++) begin
            m_frame[i] = 0;
            m_dir[i]   = 0;
            m_ticks[i] = 0;
        end
        m_prev_state = '0;
        m_prev_valid = 0;
        exp_addr     = '0;
        exp_obj      = 1'b0;
        exp_open     = '0;
    endtask

    // Predicts the outputs after the coming clock edge from the inputs now on the bus.
    task automatic updateModel();
        int x, y, win, a;
        bit changed;
`ifdef DOOR_ANIM_EN
        int want;
`endif
        if (rst) begin
            resetModel();
            return;
        end
        x   = int'(bus.h_cnt) / 2;
        y   = int'(bus.v_cnt) / 2;
        win = -1;
        for (int i = 0; i < N; i++)
            if (win < 0 && x >= door_x[i] && x < door_x[i] + SW && y >= door_y[i] && y < door_y[i] + SH)
                win = i;
        if (win >= 0 && (bus.state == STAGE1 || bus.state == STAGE2 || bus.state == STAGE3)) begin
            a        = (x - door_x[win] + 120 + m_frame[win] * SW) + (y - door_y[win] + 40) * SCREEN_W;
            exp_obj  = 1'b1;
            exp_addr = (a < SHEET_SIZE) ? 17'(a) : 17'd0;
        end else begin
            exp_obj  = 1'b0;
            exp_addr = '0;
        end
        changed = m_prev_valid && (bus.state != m_prev_state);
        for (int i = 0; i < N; i++) begin
            if (changed) begin
                m_frame[i] = 0;
                m_dir[i]   = 0;
                m_ticks[i] = 0;
            end else begin
`ifdef DOOR_ANIM_EN
                want = bus.lock[i] ? -1 : 1;
                if (m_dir[i] == 0) begin
                    if ((want > 0 && m_frame[i] == 0) || (want < 0 && m_frame[i] == F - 1)) begin
                        m_dir[i]   = want;
                        m_ticks[i] = 0;
                    end
                end else if (m_dir[i] != want) begin
                    m_dir[i]   = want;
                    m_ticks[i] = 0;
                end
                if (m_dir[i] != 0 && bus.frame_tick) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == ADIV) begin
                        m_ticks[i] = 0;
                        m_frame[i] = m_frame[i] + m_dir[i];
                        if (m_frame[i] < 0) m_frame[i] = 0;
                        if (m_frame[i] > F - 1) m_frame[i] = F - 1;
                        if (m_frame[i] == ((m_dir[i] > 0) ? F - 1 : 0)) m_dir[i] = 0;
                    end
                end
`else
                m_frame[i] = bus.lock[i] ? 0 : F - 1;
`endif
            end
            exp_open[i] = (m_dir[i] == 0 && m_frame[i] == F - 1);
        end
        m_prev_state = bus.state;
        m_prev_valid = 1;
    endtask

    // Drives one cycle of inputs at the falling edge and advances the model.
    task automatic applyStimulus(input logic r, input logic [3:0] st, input int h, input int v,
                                 input logic tk, input logic [N-1:0] lk);
        @(negedge clk);
        rst            = r;
        bus.state      = st;
        bus.h_cnt      = 10'(h);
        bus.v_cnt      = 10'(v);
        bus.frame_tick = tk;
        bus.lock       = lk;
        updateModel();
    endtask

    task automatic checkOutput();
        expectEq("pixel_addr", bus.pixel_addr, exp_addr);
        expectEq("isObject", bus.isObject, exp_obj);
        expectEq("door_open", bus.door_open, exp_open);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

`ifdef DOOR_ANIM_EN
    task automatic tickRun(input int n, input logic [3:0] st, input logic [N-1:0] lk);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, st, 520, 240, 1'b1, lk);
        applyStimulus(1'b0, st, 520, 240, 1'b0, lk);
        settle();
    endtask
`endif

    // Every cycle the registered outputs are compared with the model's prediction.
    always begin
        @(posedge clk);
        #2;
        checkOutput();
    end

    initial begin
        logic [3:0]   st;
        logic [N-1:0] lk;
        rst            = 1'b1;
        bus.state      = TITLE;
        bus.h_cnt      = '0;
        bus.v_cnt      = '0;
        bus.frame_tick = 1'b0;
        bus.lock       = '1;
        resetModel();

        repeat (3) applyStimulus(1'b1, TITLE, 0, 0, 1'b0, 4'hF);
        settle();
        expectEq("reset_obj", bus.isObject, 0);
        expectEq("reset_addr", bus.pixel_addr, 0);
        expectEq("reset_open", bus.door_open, 0);

        applyStimulus(1'b0, STAGE1, 520, 240, 1'b0, 4'hF);
        settle();
        expectEq("door0_obj", bus.isObject, 1);
        expectEq("door0_addr", bus.pixel_addr, 12920);

        applyStimulus(1'b0, STAGE1, 520, 240, 1'b0, 4'hE);
        settle();
`ifndef DOOR_ANIM_EN
        expectEq("unlock_open0", bus.door_open[0], 1);
`endif
        applyStimulus(1'b0, STAGE1, 520, 240, 1'b0, 4'hE);
        settle();
`ifdef DOOR_ANIM_EN
        expectEq("unlock_addr", bus.pixel_addr, 12920);
`else
        expectEq("unlock_addr", bus.pixel_addr, 12980);
`endif

        applyStimulus(1'b0, STAGE1, 200, 200, 1'b0, 4'b1010);
        applyStimulus(1'b0, STAGE1, 200, 200, 1'b0, 4'b1010);
        settle();
        expectEq("overlap_addr", bus.pixel_addr, 16130);

        applyStimulus(1'b0, STAGE1, 520, 240, 1'b0, 4'b1010);
        applyStimulus(1'b0, SUCCESS1, 520, 240, 1'b0, 4'b1010);
        settle();
        expectEq("success_obj", bus.isObject, 0);
        expectEq("success_addr", bus.pixel_addr, 0);
        expectEq("success_open", bus.door_open, 0);
        applyStimulus(1'b0, STAGE2, 520, 240, 1'b0, 4'b1010);
        settle();
        expectEq("stage2_obj", bus.isObject, 1);
        expectEq("stage2_addr", bus.pixel_addr, 12920);
        expectEq("stage2_open0", bus.door_open[0], 0);

`ifdef DOOR_ANIM_EN
        tickRun(6, STAGE2, 4'b1010);
        expectEq("open_f1_addr", bus.pixel_addr, 12940);
        tickRun(6, STAGE2, 4'b1010);
        expectEq("open_f2_addr", bus.pixel_addr, 12960);
        tickRun(6, STAGE2, 4'b1011);
        expectEq("close_f1_addr", bus.pixel_addr, 12940);
        tickRun(6, STAGE2, 4'b1011);
        expectEq("close_f0_addr", bus.pixel_addr, 12920);
        expectEq("closed_open0", bus.door_open[0], 0);
        tickRun(18, STAGE2, 4'b1010);
        expectEq("full_open_addr", bus.pixel_addr, 12980);
        expectEq("full_open0", bus.door_open[0], 1);
`endif
        applyStimulus(1'b0, SUCCESS2, 520, 240, 1'b0, 4'b1010);
        applyStimulus(1'b0, STAGE3, 520, 240, 1'b0, 4'b1010);
`ifdef DOOR_ANIM_EN
        tickRun(12, STAGE3, 4'b1010);
        expectEq("mid_open_addr", bus.pixel_addr, 12960);
`endif
        applyStimulus(1'b0, STAGE3, 520, 240, 1'b0, 4'b1010);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        expectEq("async_obj", bus.isObject, 0);
        expectEq("async_addr", bus.pixel_addr, 0);
        expectEq("async_open", bus.door_open, 0);
        applyStimulus(1'b1, STAGE3, 520, 240, 1'b0, 4'hF);
        applyStimulus(1'b0, STAGE3, 520, 240, 1'b0, 4'hF);
        settle();
        expectEq("release_addr", bus.pixel_addr, 12920);

        st = STAGE1;
        lk = 4'hF;
        for (int c = 0; c < 3000; c++) begin
            int d, h, v;
            bit r;
            if ($urandom_range(0, 149) == 0) begin
                if ($urandom_range(0, 1) == 1) st = 4'(2 * $urandom_range(1, 3));
                else st = 4'($urandom_range(0, 8));
            end
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 39) == 0) lk[i] = ~lk[i];
            if ($urandom_range(0, 3) != 0) begin
                d = int'($urandom_range(0, N - 1));
                h = 2 * (door_x[d] + int'($urandom_range(0, 23)) - 2) + int'($urandom_range(0, 1));
                v = 2 * (door_y[d] + int'($urandom_range(0, 23)) - 2) + int'($urandom_range(0, 1));
            end else begin
                h = int'($urandom_range(0, 639));
                v = int'($urandom_range(0, 479));
            end
            r = ($urandom_range(0, 999) == 0);
            applyStimulus(r, st, h, v, 1'($urandom_range(0, 1)), lk);
        end

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
